// File: rtl/mmio_bus_fabric.sv
// rtl/mmio_bus_fabric.sv - parametrised CPU read-data fabric with DTAck, wait states and bus errors
//
// Purpose:
//   Sits between the CPU bus (AS_L/WE_L/DTAck) and N_SLAVES memory-mapped slaves.
//   It returns registered read data and terminates each access with DTAck. The
//   termination comes after a fixed per-slave wait count or after a slave ready
//   handshake. Decode faults and ready timeouts are reported on Bus_Error_H.
//
// Optional feature macro: BUS_FABRIC_ERR_COUNT_EN
//   Defined     : Err_Count counts error terminations and saturates at 16'hFFFF.
//   Not defined : Err_Count is tied to zero.
//
// Ports:
//   Clock          in   1                 system clock
//   Reset_L        in   1                 synchronous active-low reset
//   AS_L           in   1                 CPU address strobe, active low
//   WE_L           in   1                 CPU write enable, active low (high = read)
//   Select_H       in   N_SLAVES          one-hot slave selects from address decoder
//   Slave_Ready_H  in   N_SLAVES          per-slave completion for ready-handshake slaves
//   Slave_DataIn   in   N_SLAVES*DATA_W   packed slave read data, slave i at [i*DATA_W +: DATA_W]
//   DataOut_CPU    out  DATA_W            registered read data to CPU
//   DTAck          out  1                 data transfer acknowledge
//   Bus_Error_H    out  1                 marks the current DTAck as an error termination
//   Err_Count      out  16                error termination counter

module mmio_bus_fabric #(
  parameter int                    N_SLAVES       = 8,
  parameter int                    DATA_W         = 32,
  parameter logic [N_SLAVES*4-1:0] WAIT_STATES    = '0,
  parameter logic [N_SLAVES-1:0]   READY_MASK     = '0,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                       Clock,
  input  logic                       Reset_L,
  input  logic                       AS_L,
  input  logic                       WE_L,
  input  logic [N_SLAVES-1:0]        Select_H,
  input  logic [N_SLAVES-1:0]        Slave_Ready_H,
  input  logic [N_SLAVES*DATA_W-1:0] Slave_DataIn,
  output logic [DATA_W-1:0]          DataOut_CPU,
  output logic                       DTAck,
  output logic                       Bus_Error_H,
  output logic [15:0]                Err_Count
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

  state_t              state;
  logic [N_SLAVES-1:0] sel_q;
  logic                we_q;
  logic                err_q;
  logic                rdy_q;
  logic [15:0]         cnt;

  logic                sel_onehot;
  logic [3:0]          new_wait;
  logic                new_rdy;
  logic                ready_hit;
  logic [DATA_W-1:0]   sel_data;

  // Decode the incoming select vector. The per-slave attributes are only
  // meaningful when the select is one-hot, which gates their use below.
  always_comb begin
    sel_onehot = (Select_H != '0) && ((Select_H & (Select_H - 1'b1)) == '0);
    new_wait   = 4'd0;
    new_rdy    = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (Select_H[i]) begin
        new_wait = WAIT_STATES[i*4 +: 4];
        new_rdy  = READY_MASK[i];
      end
    end
  end

  // sel_q is one-hot whenever it is used, so an OR-reduction acts as the mux.
  always_comb begin
    ready_hit = |(Slave_Ready_H & sel_q);
    sel_data  = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) begin
        sel_data = sel_data | Slave_DataIn[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      state       <= IDLE;
      DataOut_CPU <= '0;
      DTAck       <= 1'b0;
      Bus_Error_H <= 1'b0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      rdy_q       <= 1'b0;
      cnt         <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!AS_L) begin
            sel_q <= Select_H;
            we_q  <= WE_L;
            if (!sel_onehot) begin
              err_q <= 1'b1;
              state <= ACK;
            end else begin
              err_q <= 1'b0;
              rdy_q <= new_rdy;
              if (new_rdy) begin
                cnt   <= 16'(TIMEOUT_CYCLES);
                state <= WAIT;
              end else begin
                cnt   <= {12'd0, new_wait};
                state <= (new_wait != 4'd0) ? WAIT : ACK;
              end
            end
          end
        end
        WAIT: begin
          if (AS_L) begin
            // CPU abandoned the cycle: no acknowledge, outputs untouched.
            state <= IDLE;
          end else if (!rdy_q) begin
            cnt <= cnt - 16'd1;
            if (cnt == 16'd1) state <= ACK;
          end else if (ready_hit) begin
            state <= ACK;
          end else if (cnt == 16'd1) begin
            err_q <= 1'b1;
            state <= ACK;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ACK: begin
          DTAck       <= 1'b1;
          Bus_Error_H <= err_q;
          if (we_q) DataOut_CPU <= err_q ? '0 : sel_data;
          state       <= HOLD;
        end
        HOLD: begin
          // Staying here while AS_L is low prevents a held strobe from retriggering.
          if (AS_L) begin
            DTAck       <= 1'b0;
            Bus_Error_H <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUS_FABRIC_ERR_COUNT_EN
  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      Err_Count <= 16'd0;
    end else if ((state == ACK) && err_q && (Err_Count != 16'hFFFF)) begin
      Err_Count <= Err_Count + 16'd1;
    end
  end
`else
  assign Err_Count = 16'h0000;
`endif

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// tb/tb_mmio_bus_fabric.sv - directed self-checking bench for mmio_bus_fabric

module tb_mmio_bus_fabric;

  localparam int NS = 4;
  localparam int DW = 32;

  logic           Clock = 1'b0;
  logic           Reset_L;
  logic           AS_L;
  logic           WE_L;
  logic [NS-1:0]  Select_H;
  logic [NS-1:0]  Slave_Ready_H;
  logic [NS*DW-1:0] Slave_DataIn;
  logic [DW-1:0]  DataOut_CPU;
  logic           DTAck;
  logic           Bus_Error_H;
  logic [15:0]    Err_Count;

  int tests = 0;
  int fails = 0;

  // Slave 1 has 3 fixed waits, slave 3 uses the ready handshake, others zero waits.
  mmio_bus_fabric #(
    .N_SLAVES      (NS),
    .DATA_W        (DW),
    .WAIT_STATES   (16'h0030),
    .READY_MASK    (4'b1000),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .Clock        (Clock),
    .Reset_L      (Reset_L),
    .AS_L         (AS_L),
    .WE_L         (WE_L),
    .Select_H     (Select_H),
    .Slave_Ready_H(Slave_Ready_H),
    .Slave_DataIn (Slave_DataIn),
    .DataOut_CPU  (DataOut_CPU),
    .DTAck        (DTAck),
    .Bus_Error_H  (Bus_Error_H),
    .Err_Count    (Err_Count)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifdef BUS_FABRIC_ERR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  initial begin
    Reset_L       = 1'b0;
    AS_L          = 1'b1;
    WE_L          = 1'b1;
    Select_H      = '0;
    Slave_Ready_H = '0;
    Slave_DataIn  = {32'h33333333, 32'hCAFE0002, 32'h11111111, 32'hA0A00000};
    tick; tick;
    chk("rst_dtack", 64'(DTAck), 64'd0);
    chk("rst_data", 64'(DataOut_CPU), 64'd0);
    chk("rst_berr", 64'(Bus_Error_H), 64'd0);
    chk("rst_errcnt", 64'(Err_Count), 64'd0);
    Reset_L = 1'b1;
    tick;

    // Zero-wait read of slave 2
    Select_H = 4'b0100; AS_L = 1'b0;
    tick;                                      // E0
    chk("t1_e0_dtack", 64'(DTAck), 64'd0);
    tick;                                      // E0+1
    chk("t1_dtack", 64'(DTAck), 64'd1);
    chk("t1_data", 64'(DataOut_CPU), 64'hCAFE0002);
    chk("t1_berr", 64'(Bus_Error_H), 64'd0);
    tick;
    chk("t1_hold", 64'(DTAck), 64'd1);
    AS_L = 1'b1;
    tick;
    chk("t1_release", 64'(DTAck), 64'd0);
    chk("t1_retain", 64'(DataOut_CPU), 64'hCAFE0002);

    // Three fixed waits on slave 1; select change after E0 is ignored
    Select_H = 4'b0010; AS_L = 1'b0;
    tick;                                      // E0
    Select_H = 4'b0100;
    tick; tick; tick;                          // E0+3
    chk("t2_e3_dtack", 64'(DTAck), 64'd0);
    tick;                                      // E0+4
    chk("t2_dtack", 64'(DTAck), 64'd1);
    chk("t2_data", 64'(DataOut_CPU), 64'h11111111);
    AS_L = 1'b1;
    tick;
    chk("t2_release", 64'(DTAck), 64'd0);

    // Ready handshake on slave 3, ready seen at E0+5
    Select_H = 4'b1000; AS_L = 1'b0;
    tick;                                      // E0
    tick; tick; tick; tick;                    // E0+4
    Slave_Ready_H = 4'b1000;
    tick;                                      // E0+5
    Slave_Ready_H = 4'b0000;
    chk("t3_e5_dtack", 64'(DTAck), 64'd0);
    tick;                                      // E0+6
    chk("t3_dtack", 64'(DTAck), 64'd1);
    chk("t3_berr", 64'(Bus_Error_H), 64'd0);
    chk("t3_data", 64'(DataOut_CPU), 64'h33333333);
    AS_L = 1'b1;
    tick;

    // Ready never arrives: timeout after 10 WAIT cycles
    Select_H = 4'b1000; AS_L = 1'b0;
    tick;                                      // E0
    repeat (10) tick;                          // E0+10
    chk("t4_e10_dtack", 64'(DTAck), 64'd0);
    tick;                                      // E0+11
    chk("t4_dtack", 64'(DTAck), 64'd1);
    chk("t4_berr", 64'(Bus_Error_H), 64'd1);
    chk("t4_data", 64'(DataOut_CPU), 64'd0);
    chk("t4_errcnt", 64'(Err_Count), CNT_EN ? 64'd1 : 64'd0);
    AS_L = 1'b1;
    tick;
    chk("t4_berr_clr", 64'(Bus_Error_H), 64'd0);

    // Decode faults: no select, then two selects
    Select_H = 4'b0000; AS_L = 1'b0;
    tick; tick;
    chk("t5a_dtack", 64'(DTAck), 64'd1);
    chk("t5a_berr", 64'(Bus_Error_H), 64'd1);
    AS_L = 1'b1;
    tick;
    Select_H = 4'b0110; AS_L = 1'b0;
    tick; tick;
    chk("t5b_dtack", 64'(DTAck), 64'd1);
    chk("t5b_berr", 64'(Bus_Error_H), 64'd1);
    chk("t5_errcnt", 64'(Err_Count), CNT_EN ? 64'd3 : 64'd0);
    AS_L = 1'b1;
    tick;

    // Write to slave 0 leaves read data register untouched
    Select_H = 4'b0001; WE_L = 1'b0; AS_L = 1'b0;
    tick; tick;
    chk("wr_dtack", 64'(DTAck), 64'd1);
    chk("wr_data", 64'(DataOut_CPU), 64'd0);
    tick; tick;                                // strobe held low: no retrigger
    chk("wr_hold", 64'(DTAck), 64'd1);
    AS_L = 1'b1; WE_L = 1'b1;
    tick;

    // Abort during WAIT, then a normal access, then reset during HOLD
    Select_H = 4'b0010; AS_L = 1'b0;
    tick; tick;
    AS_L = 1'b1;
    tick; tick; tick;
    chk("t6_abort", 64'(DTAck), 64'd0);
    chk("t6_abort_data", 64'(DataOut_CPU), 64'd0);
    Select_H = 4'b0100; AS_L = 1'b0;
    tick; tick;
    chk("t6_next_dtack", 64'(DTAck), 64'd1);
    chk("t6_next_data", 64'(DataOut_CPU), 64'hCAFE0002);
    Reset_L = 1'b0;
    tick;
    chk("t6_rst_dtack", 64'(DTAck), 64'd0);
    chk("t6_rst_data", 64'(DataOut_CPU), 64'd0);
    chk("t6_rst_errcnt", 64'(Err_Count), 64'd0);
    Reset_L = 1'b1; AS_L = 1'b1;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
